// File: rtl/frontend_cmd_responder.sv
// Frontend command endpoint: accepts host commands, attaches the trailing write
// beat, queues entries in an in-order FIFO for the backend scheduler, limits
// outstanding reads and forwards returned read data to the host.
module frontend_cmd_responder #(
  parameter int CMD_W  = 31,
  parameter int DATA_W = 1024,
  parameter int DEPTH  = 8,
  parameter int MAX_RD = 4
) (
  input  logic              clk,
  input  logic              power_on_rst_n,
  input  logic [CMD_W-1:0]  command,
  input  logic              valid,
  input  logic [DATA_W-1:0] write_data,
  output logic              ba_cmd_pm,
  output logic [DATA_W-1:0] read_data,
  output logic              read_data_valid,
  output logic [CMD_W-1:0]  be_cmd,
  output logic [DATA_W-1:0] be_wdata,
  output logic              be_valid,
  input  logic              be_ready,
  input  logic [DATA_W-1:0] be_rdata,
  input  logic              be_rdata_valid,
  output logic              rd_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RDC_W = $clog2(MAX_RD) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [RDC_W-1:0] RD_LIMIT = RDC_W'(MAX_RD);

  logic [CMD_W-1:0]  cmd_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, pend_idx;
  logic [CNT_W-1:0]  count;
  logic [RDC_W-1:0]  rd_cnt;
  logic              wdata_pend;

  logic not_empty, head_is_read, head_pending, rd_blocked;
  logic push, push_write, pop, rd_inc, rd_dec;

  // Handshake qualifiers and head-of-queue dispatch gating.
  always_comb begin
    not_empty    = (count != '0);
    head_is_read = cmd_mem[rd_ptr][CMD_W-1];
    head_pending = wdata_pend & (pend_idx == rd_ptr);
    rd_blocked   = head_is_read & (rd_cnt == RD_LIMIT);
    // Ready is forced low while reset is asserted, not just after the first edge.
    ba_cmd_pm    = power_on_rst_n & (count != FULL_CNT);
    be_valid     = not_empty & ~head_pending & ~rd_blocked;
    be_cmd       = not_empty ? cmd_mem[rd_ptr]  : '0;
    be_wdata     = not_empty ? data_mem[rd_ptr] : '0;
    push         = valid & ba_cmd_pm;
    push_write   = push & ~command[CMD_W-1];
    pop          = be_valid & be_ready;
    rd_inc       = pop & head_is_read;
    rd_dec       = be_rdata_valid & (rd_cnt != '0);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Track the single write entry still waiting for its data beat.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      wdata_pend <= 1'b0;
      pend_idx   <= '0;
    end else if (push_write) begin
      wdata_pend <= 1'b1;
      pend_idx   <= wr_ptr;
    end else begin
      wdata_pend <= 1'b0;
    end
  end

  // Entry storage; occupancy is what gives an entry meaning, so no reset here.
  always_ff @(posedge clk) begin
    if (push) cmd_mem[wr_ptr] <= command;
    if (push && command[CMD_W-1]) data_mem[wr_ptr] <= '0;
    if (wdata_pend) data_mem[pend_idx] <= write_data;
  end

  // Outstanding-read accounting, read return and sticky underflow error.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      rd_cnt          <= '0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
      rd_err          <= 1'b0;
    end else begin
      case ({rd_inc, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
      read_data_valid <= rd_dec;
      if (rd_dec) read_data <= be_rdata;
      if (be_rdata_valid && (rd_cnt == '0)) rd_err <= 1'b1;
    end
  end

endmodule

// File: doc/frontend_cmd_responder.md
Name: frontend_cmd_responder

Overview:
Controller-side endpoint of the frontend command interface: accepts host commands on the valid/ba_cmd_pm handshake, captures the trailing write data, and buffers both in a command FIFO. It dispatches buffered entries in order to the backend scheduler over a valid/ready handshake and returns backend read data to the host on read_data/read_data_valid. It sits between the host traffic source and the command scheduler.

Parameters:
CMD_W, 31, frontend command width; bit CMD_W-1 is op_type (0 = WRITE, 1 = READ)
DATA_W, 1024, datapath width (DQ_BITS*8)
DEPTH, 8, command FIFO entries (power of two, >=2)
MAX_RD, 4, maximum outstanding backend reads

Ports:
clk  input  1  system clock
power_on_rst_n  input  1  asynchronous active-low reset
command  input  CMD_W  host command {op_type, data_type, row_addr, col_addr}
valid  input  1  host command valid
write_data  input  DATA_W  write payload; valid the cycle AFTER its write command handshake
ba_cmd_pm  output  1  ready to host; 1 = FIFO can accept
read_data  output  DATA_W  read payload to host
read_data_valid  output  1  read_data qualifier, one-cycle pulse per beat
be_cmd  output  CMD_W  command to scheduler (FIFO head)
be_wdata  output  DATA_W  write data of FIFO head
be_valid  output  1  head entry available for dispatch
be_ready  input  1  scheduler accepts be_cmd
be_rdata  input  DATA_W  scheduler read data, in issue order
be_rdata_valid  input  1  be_rdata qualifier
rd_err  output  1  sticky: be_rdata_valid seen with zero outstanding reads

Behaviour:
- Reset (async, power_on_rst_n=0): FIFO empty, pointers 0, wdata_pend=0, rd_cnt=0; ba_cmd_pm=1 after release (0 while in reset); read_data=0, read_data_valid=0, be_valid=0, be_cmd=0, be_wdata=0, rd_err=0. Reset mid-transfer discards all entries, pending write data and outstanding count.
- Host accept: handshake when valid & ba_cmd_pm at posedge; command stored at wr_ptr, wr_ptr increments (wraps modulo DEPTH), count+1.
- ba_cmd_pm = (count != DEPTH), combinational from registered count; no accept when full even if a pop occurs that cycle.
- Write-data capture: on accepting a WRITE, set wdata_pend and remember index; at the next posedge store write_data into that entry and clear wdata_pend. If another WRITE is accepted on that same edge, wdata_pend stays 1 for the new index. READ entries store data 0.
- Dispatch: be_valid = (count != 0) & ~(head is the pending-data entry) & ~(head is READ & rd_cnt == MAX_RD). be_cmd/be_wdata driven combinationally from head. Pop on be_valid & be_ready: rd_ptr+1 (wrap), count-1.
- Simultaneous push and pop: count unchanged; works at count==DEPTH-? and count==1 (pop of a complete entry while new one is pushed).
- Outstanding reads: rd_cnt +1 on READ pop, -1 on be_rdata_valid (when rd_cnt>0); both same cycle -> unchanged. be_rdata_valid with rd_cnt==0: no decrement, rd_err set (sticky until reset), data still not forwarded.
- Read return: 1-cycle latency; read_data <= be_rdata and read_data_valid <= 1 on the edge sampling be_rdata_valid (and rd_cnt>0); else read_data_valid <= 0, read_data holds.
- Ordering strictly in-order; commands are never reordered or merged; no backpressure on read return (host always accepts).
- Widths: count is $clog2(DEPTH)+1 bits; rd_cnt $clog2(MAX_RD)+1 bits; no saturation needed beyond stated guards.

Test Plan:
- Reset then single WRITE row 0 col 3, write_data=0x33 next cycle, be_ready=1 -> be_valid rises one cycle after data capture; be_cmd op=0, be_wdata=0x33.
- 8 back-to-back WRITEs, be_ready=0 -> ba_cmd_pm drops to 0 after 8th accept; 9th held; raise be_ready -> 8 pops in order, data rr*16+cc matches each entry.
- WRITE accepted into empty FIFO with be_ready=1 -> be_valid stays 0 the accept cycle (data pending), asserts next cycle; no pop of zero data.
- 6 READs, be_ready=1, no return -> exactly 4 dispatched, be_valid 0 with READ at head; one be_rdata_valid (0xAB) -> read_data=0xAB, read_data_valid pulse one cycle later, 5th READ dispatches.
- be_rdata_valid with rd_cnt=0 -> rd_err=1 and stays 1, read_data_valid stays 0; reset -> rd_err=0.
- Assert power_on_rst_n=0 with 5 entries and 2 reads outstanding -> all outputs to reset values immediately; after release FIFO empty, ba_cmd_pm=1.
